// File: rtl/gl_prim_assembler.sv
// Primitive assembler: pops vertex/color FIFO words in lockstep, groups them into
// triangles (list, strip or fan) and presents each one with a valid/accept handshake.
module gl_prim_assembler #(
  parameter int DW = 96,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    prim_mode,
  input  logic          prim_restart,
  input  logic          vertex_empty,
  input  logic          color_empty,
  input  logic [DW-1:0] vertex_rd_data,
  input  logic [DW-1:0] color_rd_data,
  output logic          vertex_rd_en,
  output logic          color_rd_en,
  output logic          tri_valid,
  input  logic          tri_accept,
  output logic [DW-1:0] vertex_out1,
  output logic [DW-1:0] vertex_out2,
  output logic [DW-1:0] vertex_out3,
  output logic [DW-1:0] color_out1,
  output logic [DW-1:0] color_out2,
  output logic [DW-1:0] color_out3,
  output logic [CW-1:0] tri_count
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  localparam logic [1:0] MODE_STRIP = 2'd1;
  localparam logic [1:0] MODE_FAN   = 2'd2;

  state_t        state_q;
  logic [1:0]    cnt_q;
  logic [1:0]    mode_q;
  logic          parity_q;
  logic          pend_q;
  logic          valid_q;
  logic [CW-1:0] tri_count_q;
  logic [DW-1:0] slot_v_q [3];
  logic [DW-1:0] slot_c_q [3];
  logic [DW-1:0] vo1_q, vo2_q, vo3_q;
  logic [DW-1:0] co1_q, co2_q, co3_q;
  logic          rd_en_s;

  // Pop only when both FIFOs hold a word, so vertex and color never drift apart.
  assign rd_en_s = ~reset & (state_q == S_FETCH) & ~vertex_empty & ~color_empty
                   & (cnt_q != 2'd3);

  assign vertex_rd_en = rd_en_s;
  assign color_rd_en  = rd_en_s;
  assign tri_valid    = valid_q;
  assign tri_count    = tri_count_q;
  assign vertex_out1  = vo1_q;
  assign vertex_out2  = vo2_q;
  assign vertex_out3  = vo3_q;
  assign color_out1   = co1_q;
  assign color_out2   = co2_q;
  assign color_out3   = co3_q;

  // Assembler FSM, slot storage and registered triangle outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      cnt_q       <= 2'd0;
      mode_q      <= 2'd0;
      parity_q    <= 1'b0;
      pend_q      <= 1'b0;
      valid_q     <= 1'b0;
      tri_count_q <= '0;
      vo1_q       <= '0;
      vo2_q       <= '0;
      vo3_q       <= '0;
      co1_q       <= '0;
      co2_q       <= '0;
      co3_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        slot_v_q[i] <= '0;
        slot_c_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          // A restart also latches the mode, since a word popped this cycle starts the new primitive.
          if (prim_restart) begin
            cnt_q    <= 2'd0;
            parity_q <= 1'b0;
            mode_q   <= prim_mode;
          end else if (cnt_q == 2'd0) begin
            mode_q <= prim_mode;
          end
          if (rd_en_s) begin
            state_q <= S_WAIT;
          end else if ((cnt_q == 2'd3) && !prim_restart) begin
            state_q <= S_PRESENT;
            valid_q <= 1'b1;
            if ((mode_q == MODE_STRIP) && parity_q) begin
              vo1_q <= slot_v_q[1];
              vo2_q <= slot_v_q[0];
              co1_q <= slot_c_q[1];
              co2_q <= slot_c_q[0];
            end else begin
              vo1_q <= slot_v_q[0];
              vo2_q <= slot_v_q[1];
              co1_q <= slot_c_q[0];
              co2_q <= slot_c_q[1];
            end
            vo3_q <= slot_v_q[2];
            co3_q <= slot_c_q[2];
          end
        end
        S_WAIT: begin
          if (prim_restart || pend_q) begin
            cnt_q    <= 2'd0;
            parity_q <= 1'b0;
            pend_q   <= 1'b0;
          end else begin
            slot_v_q[cnt_q] <= vertex_rd_data;
            slot_c_q[cnt_q] <= color_rd_data;
            cnt_q           <= cnt_q + 2'd1;
          end
          state_q <= S_FETCH;
        end
        S_PRESENT: begin
          if (prim_restart) begin
            pend_q <= 1'b1;
          end
          if (tri_accept) begin
            valid_q     <= 1'b0;
            tri_count_q <= tri_count_q + CW'(1);
            state_q     <= S_FETCH;
            if (prim_restart || pend_q) begin
              cnt_q    <= 2'd0;
              parity_q <= 1'b0;
              pend_q   <= 1'b0;
            end else begin
              case (mode_q)
                MODE_STRIP: begin
                  slot_v_q[0] <= slot_v_q[1];
                  slot_v_q[1] <= slot_v_q[2];
                  slot_c_q[0] <= slot_c_q[1];
                  slot_c_q[1] <= slot_c_q[2];
                  cnt_q       <= 2'd2;
                  parity_q    <= ~parity_q;
                end
                MODE_FAN: begin
                  slot_v_q[1] <= slot_v_q[2];
                  slot_c_q[1] <= slot_c_q[2];
                  cnt_q       <= 2'd2;
                end
                default: begin
                  cnt_q <= 2'd0;
                end
              endcase
            end
          end
        end
        default: begin
          state_q <= S_FETCH;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gl_prim_assembler.sv
// Scoreboard bench for gl_prim_assembler: FIFO models feed tagged words, a list/strip/fan
// reference model queues expected triangles, and a monitor checks every handshake.
module tb_gl_prim_assembler;
  localparam int DW = 96;
  localparam int CW = 16;

  logic          clk, reset;
  logic [1:0]    prim_mode;
  logic          prim_restart, vertex_empty, color_empty;
  logic [DW-1:0] vertex_rd_data, color_rd_data;
  logic          vertex_rd_en, color_rd_en, tri_valid, tri_accept;
  logic [DW-1:0] vertex_out1, vertex_out2, vertex_out3;
  logic [DW-1:0] color_out1, color_out2, color_out3;
  logic [CW-1:0] tri_count;

  int tests = 0;
  int fails = 0;
  int pops = 0;
  int bad_pop = 0;
  int bad_pair = 0;
  int acc_mode = 0;
  logic [CW-1:0] hs_count = '0;
  logic          pop_req = 1'b0;
  logic [31:0]   vq[$];
  logic [31:0]   cq[$];
  logic [31:0]   tq[$];
  logic [95:0]   expq[$];
  logic [95:0]   mon_e;

  gl_prim_assembler #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .prim_mode(prim_mode), .prim_restart(prim_restart),
    .vertex_empty(vertex_empty), .color_empty(color_empty),
    .vertex_rd_data(vertex_rd_data), .color_rd_data(color_rd_data),
    .vertex_rd_en(vertex_rd_en), .color_rd_en(color_rd_en),
    .tri_valid(tri_valid), .tri_accept(tri_accept),
    .vertex_out1(vertex_out1), .vertex_out2(vertex_out2), .vertex_out3(vertex_out3),
    .color_out1(color_out1), .color_out2(color_out2), .color_out3(color_out3),
    .tri_count(tri_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [95:0] vword(input logic [31:0] t);
    return {32'h1111_1111, ~t, t};
  endfunction

  function automatic logic [95:0] cword(input logic [31:0] t);
    return {32'h2222_2222, t, ~t};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [287:0] act, input logic [287:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FIFO model: a pop requested at a rising edge presents its word by the next one.
  always @(posedge clk) begin
    if (vertex_rd_en !== color_rd_en) bad_pair++;
    if (vertex_rd_en === 1'b1) pops++;
    pop_req <= (vertex_rd_en === 1'b1);
  end

  always @(negedge clk) begin
    if (pop_req) begin
      if (vq.size() == 0 || cq.size() == 0) bad_pop++;
      if (vq.size() > 0) vertex_rd_data = vword(vq.pop_front());
      if (cq.size() > 0) color_rd_data = cword(cq.pop_front());
      vertex_empty = (vq.size() == 0);
      color_empty  = (cq.size() == 0);
    end
  end

  task automatic push_v(input logic [31:0] t);
    vq.push_back(t);
    vertex_empty = (vq.size() == 0);
  endtask

  task automatic push_c(input logic [31:0] t);
    cq.push_back(t);
    color_empty = (cq.size() == 0);
  endtask

  task automatic push_both(input logic [31:0] t);
    push_v(t);
    push_c(t);
  endtask

  // Reference model: expected triangles of a primitive built from the vertex tags in tq.
  task automatic model(input logic [1:0] m);
    int n;
    n = tq.size();
    case (m)
      2'd1: for (int i = 0; i + 2 < n; i++) begin
        if (i % 2 == 0) expq.push_back({tq[i], tq[i+1], tq[i+2]});
        else            expq.push_back({tq[i+1], tq[i], tq[i+2]});
      end
      2'd2: for (int i = 1; i + 1 < n; i++) expq.push_back({tq[0], tq[i], tq[i+1]});
      default: for (int i = 0; i + 2 < n; i += 3) expq.push_back({tq[i], tq[i+1], tq[i+2]});
    endcase
  endtask

  initial begin
    tri_accept = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (acc_mode)
        0:       tri_accept = 1'b1;
        1:       tri_accept = 1'($urandom_range(0, 1));
        default: tri_accept = 1'b0;
      endcase
    end
  end

  // Monitor: every accepted triangle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && tri_valid && tri_accept) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_tri: got v1 %h expected none", vertex_out1[31:0]);
      end else begin
        mon_e = expq.pop_front();
        check_w("tri_vertices", {vertex_out1, vertex_out2, vertex_out3},
                {vword(mon_e[95:64]), vword(mon_e[63:32]), vword(mon_e[31:0])});
        check_w("tri_colors", {color_out1, color_out2, color_out3},
                {cword(mon_e[95:64]), cword(mon_e[63:32]), cword(mon_e[31:0])});
      end
      check("tri_count", 128'(tri_count), 128'(hs_count));
      hs_count = hs_count + CW'(1);
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d triangles pending expected 0", expq.size());
      expq.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!tri_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!tri_valid) begin
      tests++;
      fails++;
      $display("FAIL valid_timeout: got tri_valid 0 expected 1");
    end
  endtask

  task automatic new_prim(input logic [1:0] m);
    @(negedge clk);
    prim_mode    = m;
    prim_restart = 1'b1;
    @(negedge clk);
    prim_restart = 1'b0;
  endtask

  task automatic run_directed(input logic [1:0] m, input int first, input int n);
    new_prim(m);
    tq.delete();
    for (int i = 0; i < n; i++) tq.push_back(32'(first + i));
    model(m);
    pops = 0;
    for (int i = 0; i < n; i++) push_both(tq[i]);
    wait_drain(300);
    check("pops", 128'(pops), 128'(n));
  endtask

  initial begin
    int k, p0, unstable;
    logic [575:0] snap;
    logic [1:0] m;
    reset = 1'b1;
    prim_mode = 2'd0;
    prim_restart = 1'b0;
    vertex_empty = 1'b1;
    color_empty = 1'b1;
    vertex_rd_data = '0;
    color_rd_data = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", 128'(tri_valid), 128'd0);
    check("reset_count", 128'(tri_count), 128'd0);
    check("reset_outs", 128'({vertex_out1[63:0], color_out3[63:0]}), 128'd0);
    check("reset_rd_en", 128'({vertex_rd_en, color_rd_en}), 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // Triangle list with first-triangle latency.
    tq.delete();
    for (int i = 1; i <= 6; i++) tq.push_back(32'(i));
    model(2'd0);
    pops = 0;
    for (int i = 0; i < 6; i++) push_both(tq[i]);
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (!tri_valid && k < 40);
    check("first_latency", 128'(k), 128'd7);
    wait_drain(300);
    check("list_pops", 128'(pops), 128'd6);
    check("list_count", 128'(tri_count), 128'd2);

    run_directed(2'd1, 1, 5);
    check("strip_count", 128'(tri_count), 128'd5);
    run_directed(2'd2, 1, 5);

    // Color FIFO empty stalls everything.
    new_prim(2'd0);
    p0 = pops;
    for (int i = 61; i <= 63; i++) push_v(32'(i));
    repeat (10) @(negedge clk);
    check("stall_pops", 128'(pops - p0), 128'd0);
    check("stall_valid", 128'(tri_valid), 128'd0);
    tq.delete();
    for (int i = 61; i <= 63; i++) tq.push_back(32'(i));
    model(2'd0);
    for (int i = 61; i <= 63; i++) push_c(32'(i));
    wait_drain(300);

    // Restart in FETCH after two strip vertices.
    new_prim(2'd1);
    push_both(32'd11);
    push_both(32'd12);
    repeat (8) @(negedge clk);
    tq.delete();
    for (int i = 7; i <= 9; i++) tq.push_back(32'(i));
    model(2'd1);
    new_prim(2'd1);
    for (int i = 7; i <= 9; i++) push_both(32'(i));
    wait_drain(300);

    // Restart while the popped word is in flight: that word is dropped.
    new_prim(2'd0);
    push_both(32'd20);
    #1;
    k = 0;
    while (!vertex_rd_en && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wait_rd_seen", 128'(vertex_rd_en), 128'd1);
    @(negedge clk);
    prim_restart = 1'b1;
    @(negedge clk);
    prim_restart = 1'b0;
    tq.delete();
    for (int i = 21; i <= 23; i++) tq.push_back(32'(i));
    model(2'd0);
    for (int i = 21; i <= 23; i++) push_both(32'(i));
    wait_drain(300);

    // Backpressure hold, then restart during PRESENT.
    acc_mode = 2;
    new_prim(2'd1);
    expq.push_back({32'd31, 32'd32, 32'd33});
    expq.push_back({32'd34, 32'd35, 32'd36});
    for (int i = 31; i <= 34; i++) push_both(32'(i));
    wait_valid(100);
    snap = {vertex_out1, vertex_out2, vertex_out3, color_out1, color_out2, color_out3};
    p0 = pops;
    unstable = 0;
    repeat (20) begin
      @(negedge clk);
      if ({vertex_out1, vertex_out2, vertex_out3, color_out1, color_out2, color_out3} !== snap
          || tri_valid !== 1'b1) unstable++;
    end
    check("hold_stable", 128'(unstable), 128'd0);
    check("hold_pops", 128'(pops - p0), 128'd0);
    prim_restart = 1'b1;
    @(negedge clk);
    prim_restart = 1'b0;
    acc_mode = 0;
    push_both(32'd35);
    push_both(32'd36);
    wait_drain(300);

    // Randomized primitives with skewed color arrival and random accept.
    for (int p = 0; p < 12; p++) begin
      m = 2'($urandom_range(0, 3));
      acc_mode = 1;
      new_prim(m);
      tq.delete();
      for (int i = 0; i < int'($urandom_range(3, 8)); i++) tq.push_back($urandom());
      model(m);
      for (int i = 0; i < tq.size(); i++) begin
        push_v(tq[i]);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        push_c(tq[i]);
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      wait_drain(600);
    end

    // Reset during PRESENT drops the triangle.
    acc_mode = 2;
    new_prim(2'd0);
    for (int i = 41; i <= 44; i++) push_both(32'(i));
    wait_valid(100);
    reset = 1'b1;
    @(negedge clk);
    check("rst_present_valid", 128'(tri_valid), 128'd0);
    check("rst_present_count", 128'(tri_count), 128'd0);
    check("rst_rd_en", 128'(vertex_rd_en), 128'd0);
    vq.delete();
    cq.delete();
    vertex_empty = 1'b1;
    color_empty = 1'b1;
    hs_count = '0;
    acc_mode = 0;
    prim_mode = 2'd0;
    reset = 1'b0;
    @(negedge clk);
    tq.delete();
    for (int i = 51; i <= 53; i++) tq.push_back(32'(i));
    model(2'd0);
    for (int i = 51; i <= 53; i++) push_both(32'(i));
    wait_drain(300);

    check("pop_while_empty", 128'(bad_pop), 128'd0);
    check("rd_en_pairing", 128'(bad_pair), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
